// File: rtl/euler_integrator.sv
// rtl/euler_integrator.sv - semi-implicit Euler step sequencer driving a combinational Q16.16 ALU
module euler_integrator #(
  parameter int N      = 32,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N-1:0]      pos_in,
  input  logic [N-1:0]      vel_in,
  input  logic [N-1:0]      acc_in,
  input  logic [N-1:0]      dt_in,
  input  logic [STEP_W-1:0] steps,
  output logic              ready,
  output logic              done,
  output logic [N-1:0]      pos_out,
  output logic [N-1:0]      vel_out,
  output logic [N-1:0]      alu_a,
  output logic [N-1:0]      alu_b,
  output logic [1:0]        alu_op,
  input  logic [N-1:0]      alu_result
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MUL_AV = 3'd1,
    ADD_V  = 3'd2,
    MUL_VP = 3'd3,
    ADD_P  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      pos_q, pos_d;
  logic [N-1:0]      vel_q, vel_d;
  logic [N-1:0]      acc_q, acc_d;
  logic [N-1:0]      dt_q, dt_d;
  logic [N-1:0]      tmp_q, tmp_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]      pos_out_q, pos_out_d;
  logic [N-1:0]      vel_out_q, vel_out_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pos_q     <= '0;
      vel_q     <= '0;
      acc_q     <= '0;
      dt_q      <= '0;
      tmp_q     <= '0;
      cnt_q     <= '0;
      pos_out_q <= '0;
      vel_out_q <= '0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      vel_q     <= vel_d;
      acc_q     <= acc_d;
      dt_q      <= dt_d;
      tmp_q     <= tmp_d;
      cnt_q     <= cnt_d;
      pos_out_q <= pos_out_d;
      vel_out_q <= vel_out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    vel_d     = vel_q;
    acc_d     = acc_q;
    dt_d      = dt_q;
    tmp_d     = tmp_q;
    cnt_d     = cnt_q;
    pos_out_d = pos_out_q;
    vel_out_d = vel_out_q;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = OP_ADD;
    ready     = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          pos_d   = pos_in;
          vel_d   = vel_in;
          acc_d   = acc_in;
          dt_d    = dt_in;
          cnt_d   = steps;
          state_d = (steps != '0) ? MUL_AV : DONE;
        end
      end
      MUL_AV: begin
        alu_op  = OP_MUL;
        alu_a   = acc_q;
        alu_b   = dt_q;
        tmp_d   = alu_result;
        state_d = ADD_V;
      end
      ADD_V: begin
        alu_a   = vel_q;
        alu_b   = tmp_q;
        vel_d   = alu_result;
        state_d = MUL_VP;
      end
      // Position uses the velocity just updated in ADD_V (semi-implicit form).
      MUL_VP: begin
        alu_op  = OP_MUL;
        alu_a   = vel_q;
        alu_b   = dt_q;
        tmp_d   = alu_result;
        state_d = ADD_P;
      end
      ADD_P: begin
        alu_a   = pos_q;
        alu_b   = tmp_q;
        pos_d   = alu_result;
        cnt_d   = cnt_q - STEP_W'(1);
        state_d = (cnt_q != STEP_W'(1)) ? MUL_AV : DONE;
      end
      DONE: begin
        done      = 1'b1;
        pos_out_d = pos_q;
        vel_out_d = vel_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pos_out = pos_out_q;
  assign vel_out = vel_out_q;

endmodule

// File: tb/tb_euler_integrator.sv
// tb/tb_euler_integrator.sv - directed self-checking bench for euler_integrator with a Q16.16 ALU model
module tb_euler_integrator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] pos_in, vel_in, acc_in, dt_in;
  logic [7:0]  steps;
  logic        ready, done;
  logic [31:0] pos_out, vel_out, alu_a, alu_b, alu_result;
  logic [1:0]  alu_op;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  euler_integrator #(.N(32), .STEP_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pos_in     (pos_in),
    .vel_in     (vel_in),
    .acc_in     (acc_in),
    .dt_in      (dt_in),
    .steps      (steps),
    .ready      (ready),
    .done       (done),
    .pos_out    (pos_out),
    .vel_out    (vel_out),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result)
  );

  // Reference fp_alu: wrapping add/sub, MUL/DIV truncate toward zero.
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
    logic signed [63:0] p;
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    p  = '0;
    case (op)
      2'b00: p = sa + sb;
      2'b01: p = sa - sb;
      2'b10: p = (sa * sb) / 64'sd65536;
      default: p = (sb == 0) ? 64'sd0 : (sa * 64'sd65536) / sb;
    endcase
    return p[31:0];
  endfunction

  assign alu_result = alu_model(alu_a, alu_b, alu_op);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request from a negedge; returns the done cycle (-1 on timeout),
  // the ALU drive seen in cycle 1, and whether any ALU drive was non-idle.
  // Returns at the negedge after done, when pos_out/vel_out are valid.
  task automatic run_req(input logic [31:0] p, input logic [31:0] v, input logic [31:0] a,
                         input logic [31:0] d, input logic [7:0] s, output int dc,
                         output logic [1:0] op1, output logic [31:0] a1, output logic [31:0] b1,
                         output logic busy);
    dc   = -1;
    busy = 1'b0;
    op1  = '0;
    a1   = '0;
    b1   = '0;
    pos_in = p; vel_in = v; acc_in = a; dt_in = d; steps = s;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    pos_in = 32'hDEAD_BEEF; vel_in = 32'h1234_5678; acc_in = 32'h7FFF_0000;
    dt_in  = 32'h0003_0000; steps = 8'hFF;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (cyc == 1) begin
        op1 = alu_op; a1 = alu_a; b1 = alu_b;
      end
      if (alu_op != 2'b00 || alu_a != 0 || alu_b != 0) busy = 1'b1;
      if (done) begin
        dc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (dc < 0) check_eq("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check_eq("done_width", 32'(done), 32'd0);
    check_eq("ready_after", 32'(ready), 32'd1);
  endtask

  int          dc;
  logic [1:0]  op1;
  logic [31:0] a1, b1;
  logic        busy;
  int          pulses;
  int          acc_n[$];
  int          done_run;

  initial begin
    rst = 1'b1; start = 1'b0;
    pos_in = '0; vel_in = '0; acc_in = '0; dt_in = '0; steps = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_pos", pos_out, 32'h0);
    check_eq("rst_vel", vel_out, 32'h0);
    check_eq("rst_alu_a", alu_a, 32'h0);
    check_eq("rst_alu_b", alu_b, 32'h0);
    check_eq("rst_alu_op", 32'(alu_op), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_req(32'h0, 32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 8'd1, dc, op1, a1, b1, busy);
    check_eq("s1_done_cycle", 32'(dc), 32'd5);
    check_eq("s1_op1", 32'(op1), 32'd2);
    check_eq("s1_a1", a1, 32'h0002_0000);
    check_eq("s1_b1", b1, 32'h0000_8000);
    check_eq("s1_vel", vel_out, 32'h0002_0000);
    check_eq("s1_pos", pos_out, 32'h0001_0000);

    run_req(32'h0, 32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 8'd2, dc, op1, a1, b1, busy);
    check_eq("s2_done_cycle", 32'(dc), 32'd9);
    check_eq("s2_vel", vel_out, 32'h0003_0000);
    check_eq("s2_pos", pos_out, 32'h0002_8000);

    run_req(32'h0, 32'h0, 32'hFFFE_0000, 32'h0000_8000, 8'd1, dc, op1, a1, b1, busy);
    check_eq("neg_done_cycle", 32'(dc), 32'd5);
    check_eq("neg_vel", vel_out, 32'hFFFF_0000);
    check_eq("neg_pos", pos_out, 32'hFFFF_8000);

    run_req(32'h0005_0000, 32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 8'd0, dc, op1, a1, b1, busy);
    check_eq("zero_done_cycle", 32'(dc), 32'd1);
    check_eq("zero_alu_idle", 32'(busy), 32'd0);
    check_eq("zero_pos", pos_out, 32'h0005_0000);
    check_eq("zero_vel", vel_out, 32'h0001_0000);

    // Reset in cycle 6 of a three-step request.
    pos_in = 32'h0; vel_in = 32'h0001_0000; acc_in = 32'h0002_0000; dt_in = 32'h0000_8000;
    steps = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_ready", 32'(ready), 32'd1);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    check_eq("mid_rst_pos", pos_out, 32'h0);
    check_eq("mid_rst_vel", vel_out, 32'h0);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check_eq("mid_rst_no_done", 32'(pulses), 32'd0);
    run_req(32'h0, 32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 8'd1, dc, op1, a1, b1, busy);
    check_eq("post_rst_done_cycle", 32'(dc), 32'd5);
    check_eq("post_rst_vel", vel_out, 32'h0002_0000);
    check_eq("post_rst_pos", pos_out, 32'h0001_0000);

    // start coinciding with rst is dropped.
    steps = 8'd1; start = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    check_eq("rst_start_ready", 32'(ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check_eq("rst_start_no_done", 32'(pulses), 32'd0);

    // start held high: accepted every 4S+2 cycles.
    pos_in = 32'h0; vel_in = 32'h0001_0000; acc_in = 32'h0002_0000; dt_in = 32'h0000_8000;
    steps = 8'd1; start = 1'b1;
    done_run = 0;
    pulses = 0;
    for (int n = 0; n < 30; n++) begin
      if (ready && start) acc_n.push_back(n);
      if (done) begin
        done_run++;
      end else if (done_run != 0) begin
        pulses++;
        check_eq("b2b_done_width", 32'(done_run), 32'd1);
        check_eq("b2b_vel", vel_out, 32'h0002_0000);
        check_eq("b2b_pos", pos_out, 32'h0001_0000);
        done_run = 0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check_eq("b2b_pulses", 32'(pulses >= 4), 32'd1);
    check_eq("b2b_accepts", 32'(acc_n.size() >= 4), 32'd1);
    for (int i = 1; i < 4 && i < acc_n.size(); i++)
      check_eq("b2b_interval", 32'(acc_n[i] - acc_n[i-1]), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
